// File: rtl/decode_wb_pipe.sv
`default_nettype none
// ============================================================================
// Module   : decode_wb_pipe
// Brief    : RV32I/E decode with register file, immediate generator, staged
//            write-back with load formatting and a load-use scoreboard.
// Revision : 1.0
// ============================================================================
module decode_wb_pipe #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [31:0]     id_inst,
    output logic            id_ready,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    output logic [XLEN-1:0] imm32,
    input  logic            ld_issue,
    input  logic [4:0]      ld_rd,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [1:0]      wb_sel,
    input  logic [XLEN-1:0] wb_alu,
    input  logic [XLEN-1:0] wb_mem,
    input  logic [XLEN-1:0] wb_pc,
    input  logic [XLEN-1:0] wb_imm,
    input  logic [2:0]      wb_funct3,
    input  logic [1:0]      wb_addr_lo,
    output logic            wb_misalign
);

    localparam int AW = $clog2(NREG);
    localparam bit c_BYP = (BYPASS != 0);

    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;

    localparam logic [1:0] c_SEL_ALU = 2'd0;
    localparam logic [1:0] c_SEL_MEM = 2'd1;
    localparam logic [1:0] c_SEL_PC4 = 2'd2;

    logic [NREG-1:0][XLEN-1:0] r_regs;
    logic [NREG-1:0]           r_busy;
    logic                      r_stg_valid;
    logic [AW-1:0]             r_stg_rd;
    logic [XLEN-1:0]           r_stg_data;

    logic [6:0]      w_op;
    logic [AW-1:0]   w_rs1, w_rs2, w_wrd, w_lrd;
    logic            w_rs1_used, w_rs2_used, w_haz1, w_haz2;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_ld_data, w_wdata;
    logic            w_ld_mis, w_is_mem, w_misal, w_stage;
    logic [NREG-1:0] w_busy_nxt;

    assign w_op  = id_inst[6:0];
    assign w_rs1 = id_inst[15 +: AW];
    assign w_rs2 = id_inst[20 +: AW];
    assign w_wrd = wb_rd[AW-1:0];
    assign w_lrd = ld_rd[AW-1:0];

    // ---------------- decode side ----------------
    always_comb begin
        imm32 = '0;
        case (w_op)
            c_OP_JALR, c_OP_LOAD, c_OP_IMM:
                imm32 = {{20{id_inst[31]}}, id_inst[31:20]};
            c_OP_STORE:
                imm32 = {{20{id_inst[31]}}, id_inst[31:25], id_inst[11:7]};
            c_OP_BRANCH:
                imm32 = {{19{id_inst[31]}}, id_inst[31], id_inst[7],
                         id_inst[30:25], id_inst[11:8], 1'b0};
            c_OP_LUI, c_OP_AUIPC:
                imm32 = {id_inst[31:12], 12'b0};
            c_OP_JAL:
                imm32 = {{11{id_inst[31]}}, id_inst[31], id_inst[19:12],
                         id_inst[20], id_inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign w_rs1_used = !((w_op == c_OP_LUI) || (w_op == c_OP_AUIPC) || (w_op == c_OP_JAL));
    assign w_rs2_used = (w_op == c_OP_REG) || (w_op == c_OP_STORE) || (w_op == c_OP_BRANCH);

    assign w_haz1 = w_rs1_used && (w_rs1 != '0) &&
                    (r_busy[w_rs1] || (!c_BYP && r_stg_valid && (r_stg_rd == w_rs1)));
    assign w_haz2 = w_rs2_used && (w_rs2 != '0) &&
                    (r_busy[w_rs2] || (!c_BYP && r_stg_valid && (r_stg_rd == w_rs2)));
    assign id_ready = !(id_valid && (w_haz1 || w_haz2));

    always_comb begin
        rdata1 = r_regs[w_rs1];
        rdata2 = r_regs[w_rs2];
        if (c_BYP && r_stg_valid && (r_stg_rd == w_rs1)) rdata1 = r_stg_data;
        if (c_BYP && r_stg_valid && (r_stg_rd == w_rs2)) rdata2 = r_stg_data;
        if (w_rs1 == '0) rdata1 = '0;
        if (w_rs2 == '0) rdata2 = '0;
    end

    // ---------------- write-back side ----------------
    assign w_byte = wb_mem[{wb_addr_lo, 3'b000} +: 8];
    assign w_half = wb_mem[{wb_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        w_ld_data = '0;
        w_ld_mis  = 1'b0;
        case (wb_funct3)
            3'b000: w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b001: begin
                w_ld_data = {{16{w_half[15]}}, w_half};
                w_ld_mis  = wb_addr_lo[0];
            end
            3'b010: begin
                w_ld_data = wb_mem;
                w_ld_mis  = (wb_addr_lo != 2'b00);
            end
            3'b100: w_ld_data = {24'b0, w_byte};
            3'b101: begin
                w_ld_data = {16'b0, w_half};
                w_ld_mis  = wb_addr_lo[0];
            end
            default: w_ld_data = '0;
        endcase
    end

    always_comb begin
        case (wb_sel)
            c_SEL_ALU: w_wdata = wb_alu;
            c_SEL_MEM: w_wdata = w_ld_data;
            c_SEL_PC4: w_wdata = wb_pc + 32'd4;
            default:   w_wdata = wb_imm;
        endcase
    end

    assign w_is_mem = wb_valid && (wb_sel == c_SEL_MEM);
    assign w_misal  = w_is_mem && w_ld_mis;
    assign w_stage  = wb_valid && (w_wrd != '0) && !w_misal;

    // A new load issue to the same rd outranks the write-back clearing it.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_is_mem) w_busy_nxt[w_wrd] = 1'b0;
        if (ld_issue && (w_lrd != '0)) w_busy_nxt[w_lrd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_regs      <= '0;
            r_busy      <= '0;
            r_stg_valid <= 1'b0;
            r_stg_rd    <= '0;
            r_stg_data  <= '0;
            wb_misalign <= 1'b0;
        end else begin
            if (r_stg_valid) r_regs[r_stg_rd] <= r_stg_data;
            r_stg_valid <= w_stage;
            if (w_stage) begin
                r_stg_rd   <= w_wrd;
                r_stg_data <= w_wdata;
            end
            r_busy      <= w_busy_nxt;
            wb_misalign <= w_misal;
        end
    end

endmodule
`default_nettype wire
